arinc708_rx_dma: RTL

ARINC708_RX_DMA -- requirements
Module: arinc708_rx_dma

---
 rtl/arinc708_rx_dma.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/arinc708_rx_dma.sv
// ARINC 708 receive DMA: round-robin services channels whose frame is ready, reads the
// frame words over Avalon-MM and streams them out on Avalon-ST. Timeout/abort: ARINC708_RXDMA_TIMEOUT_EN.
module arinc708_rx_dma #(
  parameter int REC_NUMB    = 2,
  parameter int FRAME_WORDS = 50,
  parameter int FLAG_BIT    = 0,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [REC_NUMB-1:0]          irq_in,
  output logic [$clog2(REC_NUMB)+15:0] avm_address,
  output logic                         avm_read,
  input  logic                         avm_waitrequest,
  input  logic [31:0]                  avm_readdata,
  input  logic                         avm_readdatavalid,
  output logic [31:0]                  st_data,
  output logic                         st_valid,
  input  logic                         st_ready,
  output logic                         st_sop,
  output logic                         st_eop,
  output logic                         st_error,
  output logic [$clog2(REC_NUMB)-1:0]  st_channel,
  output logic [15:0]                  frame_cnt,
  output logic                         err_timeout
);
  localparam int CH_W = $clog2(REC_NUMB);
  localparam int K_W  = $clog2(FRAME_WORDS);
  localparam int AW   = CH_W + 16;
  localparam logic [K_W-1:0] K_LAST = K_W'(FRAME_WORDS - 1);

  typedef enum logic [2:0] {IDLE, ARB, RD_FLAG, WT_FLAG, RD_WORD, WT_WORD, PUSH, ABORT} state_t;

  state_t          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d, rr_q, rr_d, rr_pick;
  logic [K_W-1:0]  k_q, k_d, k_inc;
  logic            avm_read_q, avm_read_d;
  logic [AW-1:0]   avm_address_q, avm_address_d;
  logic [31:0]     st_data_q, st_data_d;
  logic            st_valid_q, st_valid_d, st_sop_q, st_sop_d, st_eop_q, st_eop_d;
  logic [CH_W-1:0] st_channel_q, st_channel_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  int              rr_best, rr_dist;
`ifdef ARINC708_RXDMA_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_timeout_q, err_timeout_d, st_error_q, st_error_d, sop_sent_q, sop_sent_d;
`endif

  function automatic logic [15:0] word_addr(input logic [K_W-1:0] k);
    return {{(14-K_W){1'b0}}, k, 2'b00};
  endfunction

  // Pending channel at the smallest distance after the last serviced one wins.
  always_comb begin
    rr_best = REC_NUMB;
    rr_dist = 0;
    rr_pick = rr_q;
    for (int j = 0; j < REC_NUMB; j++) begin
      rr_dist = (j + 2*REC_NUMB - 1 - int'(rr_q)) % REC_NUMB;
      if (irq_in[j] && (rr_dist < rr_best)) begin
        rr_best = rr_dist;
        rr_pick = CH_W'(j);
      end
    end
  end

  assign k_inc = k_q + K_W'(1);

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    rr_d          = rr_q;
    k_d           = k_q;
    avm_read_d    = avm_read_q;
    avm_address_d = avm_address_q;
    st_data_d     = st_data_q;
    st_valid_d    = st_valid_q;
    st_sop_d      = st_sop_q;
    st_eop_d      = st_eop_q;
    st_channel_d  = st_channel_q;
    frame_cnt_d   = frame_cnt_q;
`ifdef ARINC708_RXDMA_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    err_timeout_d = 1'b0;
    st_error_d    = st_error_q;
    sop_sent_d    = sop_sent_q;
`endif
    case (state_q)
      IDLE: if (enable && (|irq_in)) state_d = ARB;
      ARB: begin
        if (|irq_in) begin
          ch_d          = rr_pick;
          rr_d          = rr_pick;
          avm_read_d    = 1'b1;
          avm_address_d = {rr_pick, 16'h4008};
          state_d       = RD_FLAG;
        end else begin
          state_d = IDLE;
        end
`ifdef ARINC708_RXDMA_TIMEOUT_EN
        sop_sent_d = 1'b0;
`endif
      end
      RD_FLAG, RD_WORD: begin
        if (!avm_waitrequest) begin
          avm_read_d = 1'b0;
          state_d    = (state_q == RD_FLAG) ? WT_FLAG : WT_WORD;
`ifdef ARINC708_RXDMA_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
        end
      end
      WT_FLAG: begin
        if (avm_readdatavalid) begin
          if (avm_readdata[FLAG_BIT]) begin
            k_d           = '0;
            avm_read_d    = 1'b1;
            avm_address_d = {ch_q, 16'h0000};
            state_d       = RD_WORD;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef ARINC708_RXDMA_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = ABORT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      WT_WORD: begin
        if (avm_readdatavalid) begin
          st_valid_d   = 1'b1;
          st_data_d    = avm_readdata;
          st_sop_d     = (k_q == '0);
          st_eop_d     = (k_q == K_LAST);
          st_channel_d = ch_q;
          state_d      = PUSH;
        end
`ifdef ARINC708_RXDMA_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = ABORT;
          // A frame already opened downstream must be closed with an error beat.
          if (sop_sent_q) begin
            st_valid_d   = 1'b1;
            st_data_d    = '0;
            st_sop_d     = 1'b0;
            st_eop_d     = 1'b1;
            st_error_d   = 1'b1;
            st_channel_d = ch_q;
          end
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      PUSH: begin
        if (st_ready) begin
          st_valid_d = 1'b0;
          st_sop_d   = 1'b0;
          st_eop_d   = 1'b0;
`ifdef ARINC708_RXDMA_TIMEOUT_EN
          if (st_sop_q) sop_sent_d = 1'b1;
`endif
          if (st_eop_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = IDLE;
          end else begin
            k_d           = k_inc;
            avm_read_d    = 1'b1;
            avm_address_d = {ch_q, word_addr(k_inc)};
            state_d       = RD_WORD;
          end
        end
      end
      ABORT: begin
`ifdef ARINC708_RXDMA_TIMEOUT_EN
        if (!st_valid_q) begin
          state_d = IDLE;
        end else if (st_ready) begin
          st_valid_d = 1'b0;
          st_eop_d   = 1'b0;
          st_error_d = 1'b0;
          state_d    = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ch_q          <= '0;
      rr_q          <= CH_W'(REC_NUMB - 1);
      k_q           <= '0;
      avm_read_q    <= 1'b0;
      avm_address_q <= '0;
      st_data_q     <= '0;
      st_valid_q    <= 1'b0;
      st_sop_q      <= 1'b0;
      st_eop_q      <= 1'b0;
      st_channel_q  <= '0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      rr_q          <= rr_d;
      k_q           <= k_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      st_data_q     <= st_data_d;
      st_valid_q    <= st_valid_d;
      st_sop_q      <= st_sop_d;
      st_eop_q      <= st_eop_d;
      st_channel_q  <= st_channel_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

`ifdef ARINC708_RXDMA_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
      st_error_q    <= 1'b0;
      sop_sent_q    <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      err_timeout_q <= err_timeout_d;
      st_error_q    <= st_error_d;
      sop_sent_q    <= sop_sent_d;
    end
  end

  assign err_timeout = err_timeout_q;
  assign st_error    = st_error_q;
`else
  assign err_timeout = 1'b0;
  assign st_error    = 1'b0;
`endif

  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign st_data     = st_data_q;
  assign st_valid    = st_valid_q;
  assign st_sop      = st_sop_q;
  assign st_eop      = st_eop_q;
  assign st_channel  = st_channel_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
